// File: rtl/axi_addr_remap_pipe.sv
// axi_addr_remap_pipe: address-remapping register slice for AXI AW and AR.
// Each AW/AR beat is translated with the first enabled rule whose window
// [start, end) contains it, then held for one cycle in a full-throughput
// stage. W, B and R pass straight through.
// Ports:
//   clk_i, rst_i                 - clock, async active-high reset
//   slv_req_i / slv_resp_o       - slave port (upstream)
//   mst_req_o / mst_resp_i       - master port (downstream)
//   rule_start_i / rule_end_i    - per-rule match window, slave address space
//   rule_base_i / rule_en_i      - per-rule target base and enable
//   aw_miss_o / ar_miss_o        - pulse on a slave handshake that hit no rule

package axi_addr_remap_pipe_pkg;
  localparam int unsigned IdWidth   = 4;
  localparam int unsigned AddrWidth = 32;
  localparam int unsigned DataWidth = 32;
  localparam int unsigned StrbWidth = DataWidth / 8;

  typedef struct packed {
    logic [IdWidth-1:0]   id;
    logic [AddrWidth-1:0] addr;
    logic [7:0]           len;
    logic [2:0]           size;
    logic [1:0]           burst;
    logic                 lock;
    logic [3:0]           cache;
    logic [2:0]           prot;
    logic [3:0]           qos;
  } ax_chan_t;

  typedef struct packed {
    logic [DataWidth-1:0] data;
    logic [StrbWidth-1:0] strb;
    logic                 last;
  } w_chan_t;

  typedef struct packed {
    logic [IdWidth-1:0] id;
    logic [1:0]         resp;
  } b_chan_t;

  typedef struct packed {
    logic [IdWidth-1:0]   id;
    logic [DataWidth-1:0] data;
    logic [1:0]           resp;
    logic                 last;
  } r_chan_t;

  typedef struct packed {
    ax_chan_t aw;
    logic     aw_valid;
    w_chan_t  w;
    logic     w_valid;
    logic     b_ready;
    ax_chan_t ar;
    logic     ar_valid;
    logic     r_ready;
  } axi_req_t;

  typedef struct packed {
    logic    aw_ready;
    logic    ar_ready;
    logic    w_ready;
    b_chan_t b;
    logic    b_valid;
    r_chan_t r;
    logic    r_valid;
  } axi_resp_t;
endpackage

module axi_addr_remap_pipe
  import axi_addr_remap_pipe_pkg::*;
#(
  parameter int unsigned NoRules      = 4,
  parameter int unsigned SlvAddrWidth = 32,
  parameter int unsigned MstAddrWidth = SlvAddrWidth,
  parameter type         slv_req_t    = axi_req_t,
  parameter type         mst_req_t    = axi_req_t,
  parameter type         resp_t       = axi_resp_t
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  slv_req_t                             slv_req_i,
  output resp_t                                slv_resp_o,
  output mst_req_t                             mst_req_o,
  input  resp_t                                mst_resp_i,
  input  logic [NoRules-1:0][SlvAddrWidth-1:0] rule_start_i,
  input  logic [NoRules-1:0][SlvAddrWidth-1:0] rule_end_i,
  input  logic [NoRules-1:0][MstAddrWidth-1:0] rule_base_i,
  input  logic [NoRules-1:0]                   rule_en_i,
  output logic                                 aw_miss_o,
  output logic                                 ar_miss_o
);

  // r_q holds both stages; its aw_valid/ar_valid double as the full flags.
  // Its W/B/R fields are never loaded and stay at their reset value.
  mst_req_t                r_q;
  mst_req_t                w_q_nxt;
  logic                    w_aw_rdy, w_ar_rdy;
  logic                    w_aw_ld, w_ar_ld;
  logic                    w_aw_drain, w_ar_drain;
  logic                    w_aw_hit, w_ar_hit;
  logic [MstAddrWidth-1:0] w_aw_addr, w_ar_addr;

  // Returns {hit, translated address}; the descending scan lets the lowest
  // matching index win. An inverted or empty window can never satisfy both bounds.
  function automatic logic [MstAddrWidth:0] f_remap(input logic [SlvAddrWidth-1:0] addr);
    logic                    hit;
    logic [SlvAddrWidth-1:0] diff;
    logic [MstAddrWidth-1:0] res;
    hit  = 1'b0;
    diff = '0;
    res  = MstAddrWidth'(addr);
    for (int i = int'(NoRules) - 1; i >= 0; i--) begin
      if (rule_en_i[i] && (addr >= rule_start_i[i]) && (addr < rule_end_i[i])) begin
        hit  = 1'b1;
        diff = addr - rule_start_i[i];
        res  = rule_base_i[i] + MstAddrWidth'(diff);
      end
    end
    return {hit, res};
  endfunction

  // Translation uses the rules present in the load cycle only.
  always_comb begin
    {w_aw_hit, w_aw_addr} = f_remap(slv_req_i.aw.addr);
    {w_ar_hit, w_ar_addr} = f_remap(slv_req_i.ar.addr);
  end

  // Stage accepts when empty or when its content leaves this cycle.
  assign w_aw_rdy   = !r_q.aw_valid || mst_resp_i.aw_ready;
  assign w_ar_rdy   = !r_q.ar_valid || mst_resp_i.ar_ready;
  assign w_aw_ld    = slv_req_i.aw_valid && w_aw_rdy;
  assign w_ar_ld    = slv_req_i.ar_valid && w_ar_rdy;
  assign w_aw_drain = r_q.aw_valid && mst_resp_i.aw_ready;
  assign w_ar_drain = r_q.ar_valid && mst_resp_i.ar_ready;

  // Next-state for both stages; a load wins over a drain (replace in place).
  always_comb begin
    w_q_nxt = r_q;
    if (w_aw_ld) begin
      w_q_nxt.aw_valid = 1'b1;
      w_q_nxt.aw.id    = slv_req_i.aw.id;
      w_q_nxt.aw.addr  = w_aw_addr;
      w_q_nxt.aw.len   = slv_req_i.aw.len;
      w_q_nxt.aw.size  = slv_req_i.aw.size;
      w_q_nxt.aw.burst = slv_req_i.aw.burst;
      w_q_nxt.aw.lock  = slv_req_i.aw.lock;
      w_q_nxt.aw.cache = slv_req_i.aw.cache;
      w_q_nxt.aw.prot  = slv_req_i.aw.prot;
      w_q_nxt.aw.qos   = slv_req_i.aw.qos;
    end else if (w_aw_drain) begin
      w_q_nxt.aw_valid = 1'b0;
    end
    if (w_ar_ld) begin
      w_q_nxt.ar_valid = 1'b1;
      w_q_nxt.ar.id    = slv_req_i.ar.id;
      w_q_nxt.ar.addr  = w_ar_addr;
      w_q_nxt.ar.len   = slv_req_i.ar.len;
      w_q_nxt.ar.size  = slv_req_i.ar.size;
      w_q_nxt.ar.burst = slv_req_i.ar.burst;
      w_q_nxt.ar.lock  = slv_req_i.ar.lock;
      w_q_nxt.ar.cache = slv_req_i.ar.cache;
      w_q_nxt.ar.prot  = slv_req_i.ar.prot;
      w_q_nxt.ar.qos   = slv_req_i.ar.qos;
    end else if (w_ar_drain) begin
      w_q_nxt.ar_valid = 1'b0;
    end
  end

  // Stage register; reset empties it immediately.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_q <= '0;
    end else begin
      r_q <= w_q_nxt;
    end
  end

  // Master side: held AW/AR, pass-through W and response readies.
  always_comb begin
    mst_req_o         = r_q;
    mst_req_o.w       = slv_req_i.w;
    mst_req_o.w_valid = slv_req_i.w_valid;
    mst_req_o.b_ready = slv_req_i.b_ready;
    mst_req_o.r_ready = slv_req_i.r_ready;
  end

  // Slave side: everything passes through except the stage readies.
  always_comb begin
    slv_resp_o          = mst_resp_i;
    slv_resp_o.aw_ready = w_aw_rdy;
    slv_resp_o.ar_ready = w_ar_rdy;
  end

  // Miss pulses coincide with the slave handshake; suppressed during reset.
  assign aw_miss_o = w_aw_ld && !w_aw_hit && !rst_i;
  assign ar_miss_o = w_ar_ld && !w_ar_hit && !rst_i;

endmodule

// File: tb/tb_axi_addr_remap_pipe.sv
// tb_axi_addr_remap_pipe: directed vectors, multi-cycle corner sequences and
// a randomized run scored against a queue-based reference of the remapper.
module tb_axi_addr_remap_pipe;
  import axi_addr_remap_pipe_pkg::*;

  localparam int unsigned NR = 4;

  typedef struct packed {
    logic [3:0]  id;
    logic [23:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic        lock;
    logic [3:0]  cache;
    logic [2:0]  prot;
    logic [3:0]  qos;
  } ax24_t;

  typedef struct packed {
    ax24_t   aw;
    logic    aw_valid;
    w_chan_t w;
    logic    w_valid;
    logic    b_ready;
    ax24_t   ar;
    logic    ar_valid;
    logic    r_ready;
  } req24_t;

  typedef struct {
    logic        is_aw;
    logic [31:0] s0, e0, b0;
    logic        en0;
    logic [31:0] s1, e1, b1;
    logic        en1;
    logic [31:0] addr;
    logic [31:0] exp_addr;
    logic        exp_miss;
  } vec_t;

  logic clk = 1'b0;
  logic rst;

  axi_req_t  slv_req, mst_req;
  axi_resp_t slv_resp, mst_resp;
  logic [NR-1:0][31:0] r_start, r_end, r_base;
  logic [NR-1:0]       r_en;
  logic                aw_miss, ar_miss;

  axi_req_t        s24_req;
  req24_t          m24_req;
  axi_resp_t       s24_resp, m24_resp;
  logic [0:0][31:0] s24_start, s24_end;
  logic [0:0][23:0] s24_base;
  logic [0:0]       s24_en;
  logic             aw_miss24, ar_miss24;

  int total = 0;
  int bad   = 0;
  ax_chan_t q_aw[$];
  ax_chan_t q_ar[$];
  vec_t     tbl[$];

  always #5 clk = ~clk;

  axi_addr_remap_pipe #(
    .NoRules(NR), .SlvAddrWidth(32), .MstAddrWidth(32),
    .slv_req_t(axi_req_t), .mst_req_t(axi_req_t), .resp_t(axi_resp_t)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .slv_req_i(slv_req), .slv_resp_o(slv_resp),
    .mst_req_o(mst_req), .mst_resp_i(mst_resp),
    .rule_start_i(r_start), .rule_end_i(r_end),
    .rule_base_i(r_base), .rule_en_i(r_en),
    .aw_miss_o(aw_miss), .ar_miss_o(ar_miss)
  );

  axi_addr_remap_pipe #(
    .NoRules(1), .SlvAddrWidth(32), .MstAddrWidth(24),
    .slv_req_t(axi_req_t), .mst_req_t(req24_t), .resp_t(axi_resp_t)
  ) dut24 (
    .clk_i(clk), .rst_i(rst),
    .slv_req_i(s24_req), .slv_resp_o(s24_resp),
    .mst_req_o(m24_req), .mst_resp_i(m24_resp),
    .rule_start_i(s24_start), .rule_end_i(s24_end),
    .rule_base_i(s24_base), .rule_en_i(s24_en),
    .aw_miss_o(aw_miss24), .ar_miss_o(ar_miss24)
  );

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic ax_chan_t rand_ax(input logic [31:0] addr);
    ax_chan_t a;
    a.id    = 4'($urandom);
    a.addr  = addr;
    a.len   = 8'($urandom);
    a.size  = 3'($urandom);
    a.burst = 2'($urandom);
    a.lock  = 1'($urandom);
    a.cache = 4'($urandom);
    a.prot  = 3'($urandom);
    a.qos   = 4'($urandom);
    return a;
  endfunction

  function automatic logic [31:0] pick_addr();
    if ($urandom_range(0, 9) == 0) return 32'($urandom);
    return 32'($urandom_range(0, 32'h3FF));
  endfunction

  // Reference: first enabled window containing a, then base + offset mod 2^32.
  function automatic logic [31:0] ref_map(input logic [31:0] a, output logic hit);
    logic [63:0] res;
    hit = 1'b0;
    res = 64'(a);
    for (int i = 0; i < int'(NR); i++) begin
      if (!hit && r_en[i] && (a >= r_start[i]) && (a < r_end[i])) begin
        hit = 1'b1;
        res = (64'(r_base[i]) + ((64'(a) - 64'(r_start[i])) % 64'h1_0000_0000)) % 64'h1_0000_0000;
      end
    end
    return 32'(res);
  endfunction

  task automatic set_rule(input int i, input logic [31:0] s, input logic [31:0] e,
                          input logic [31:0] b, input logic en);
    r_start[i] = s;
    r_end[i]   = e;
    r_base[i]  = b;
    r_en[i]    = en;
  endtask

  task automatic rand_side();
    slv_req.w.data  = $urandom;
    slv_req.w.strb  = 4'($urandom);
    slv_req.w.last  = 1'($urandom);
    slv_req.w_valid = 1'($urandom);
    slv_req.b_ready = 1'($urandom);
    slv_req.r_ready = 1'($urandom);
    mst_resp.w_ready = 1'($urandom);
    mst_resp.b       = b_chan_t'(6'($urandom));
    mst_resp.b_valid = 1'($urandom);
    mst_resp.r.id    = 4'($urandom);
    mst_resp.r.data  = $urandom;
    mst_resp.r.resp  = 2'($urandom);
    mst_resp.r.last  = 1'($urandom);
    mst_resp.r_valid = 1'($urandom);
  endtask

  task automatic chk_pass(input string nm);
    chk({nm, "_req_pass"},
        128'({mst_req.w, mst_req.w_valid, mst_req.b_ready, mst_req.r_ready}),
        128'({slv_req.w, slv_req.w_valid, slv_req.b_ready, slv_req.r_ready}));
    chk({nm, "_resp_pass"},
        128'({slv_resp.w_ready, slv_resp.b, slv_resp.b_valid, slv_resp.r, slv_resp.r_valid}),
        128'({mst_resp.w_ready, mst_resp.b, mst_resp.b_valid, mst_resp.r, mst_resp.r_valid}));
  endtask

  task automatic sb_step(input logic is_aw);
    ax_chan_t s_ax, m_ax, e_ax;
    logic     s_v, s_r, m_v, m_r, miss, hit, e_r;
    int       qn;
    string    c;
    c = is_aw ? "aw" : "ar";
    if (is_aw) begin
      s_ax = slv_req.aw; s_v = slv_req.aw_valid; s_r = slv_resp.aw_ready;
      m_ax = mst_req.aw; m_v = mst_req.aw_valid; m_r = mst_resp.aw_ready;
      miss = aw_miss;    qn  = q_aw.size();
    end else begin
      s_ax = slv_req.ar; s_v = slv_req.ar_valid; s_r = slv_resp.ar_ready;
      m_ax = mst_req.ar; m_v = mst_req.ar_valid; m_r = mst_resp.ar_ready;
      miss = ar_miss;    qn  = q_ar.size();
    end
    e_r = (qn == 0) || m_r;
    chk({c, "_slv_ready"}, 128'(s_r), 128'(e_r));
    chk({c, "_mst_valid"}, 128'(m_v), 128'(qn != 0));
    if (qn != 0) begin
      e_ax = is_aw ? q_aw[0] : q_ar[0];
      chk({c, "_mst_payload"}, 128'(m_ax), 128'(e_ax));
    end
    e_ax      = s_ax;
    e_ax.addr = ref_map(s_ax.addr, hit);
    chk({c, "_miss"}, 128'(miss), 128'(s_v && e_r && !hit));
    if (qn != 0 && m_r) begin
      if (is_aw) void'(q_aw.pop_front());
      else       void'(q_ar.pop_front());
    end
    if (s_v && e_r) begin
      if (is_aw) q_aw.push_back(e_ax);
      else       q_ar.push_back(e_ax);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    ax_chan_t ax, eax;
    ax24_t    e24;
    logic [31:0] exp_a;

    rst = 1'b1;
    slv_req = '0; mst_resp = '0;
    s24_req = '0; m24_resp = '0;
    r_start = '0; r_end = '0; r_base = '0; r_en = '0;
    s24_start = '0; s24_end = '0; s24_base = '0; s24_en = '0;

    // Reset state, with a would-be miss beat presented
    slv_req.aw_valid = 1'b1;
    slv_req.aw.addr  = 32'h5000;
    @(negedge clk); #1;
    chk("rst_aw_valid", 128'(mst_req.aw_valid), 128'(0));
    chk("rst_ar_valid", 128'(mst_req.ar_valid), 128'(0));
    chk("rst_aw_ready", 128'(slv_resp.aw_ready), 128'(1));
    chk("rst_ar_ready", 128'(slv_resp.ar_ready), 128'(1));
    chk("rst_aw_miss", 128'(aw_miss), 128'(0));
    chk("rst_aw_payload", 128'(mst_req.aw), 128'(0));
    @(negedge clk);
    slv_req = '0;
    rst = 1'b0;

    // Directed translation vectors
    tbl.push_back(vec_t'{1'b0, 32'h1000, 32'h2000, 32'h8000_0000, 1'b1, 32'h0, 32'h0, 32'h0, 1'b0, 32'h1234, 32'h8000_0234, 1'b0});
    tbl.push_back(vec_t'{1'b0, 32'h1000, 32'h2000, 32'hA000, 1'b1, 32'h1000, 32'h2000, 32'hB000, 1'b1, 32'h1800, 32'hA800, 1'b0});
    tbl.push_back(vec_t'{1'b0, 32'h1000, 32'h2000, 32'hA000, 1'b0, 32'h1000, 32'h2000, 32'hB000, 1'b1, 32'h1800, 32'hB800, 1'b0});
    tbl.push_back(vec_t'{1'b1, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h5000, 32'h5000, 1'b1});
    tbl.push_back(vec_t'{1'b1, 32'h5000, 32'h5000, 32'h9999, 1'b1, 32'h0, 32'h0, 32'h0, 1'b0, 32'h5000, 32'h5000, 1'b1});
    tbl.push_back(vec_t'{1'b0, 32'h6000, 32'h1000, 32'h0, 1'b1, 32'h0, 32'h0, 32'h0, 1'b0, 32'h3000, 32'h3000, 1'b1});
    tbl.push_back(vec_t'{1'b1, 32'h1000, 32'h2000, 32'h100, 1'b1, 32'h0, 32'h0, 32'h0, 1'b0, 32'h1FFF, 32'h10FF, 1'b0});
    tbl.push_back(vec_t'{1'b1, 32'h1000, 32'h2000, 32'h100, 1'b1, 32'h0, 32'h0, 32'h0, 1'b0, 32'h2000, 32'h2000, 1'b1});
    tbl.push_back(vec_t'{1'b0, 32'h1000, 32'h2000, 32'h100, 1'b1, 32'h0, 32'h0, 32'h0, 1'b0, 32'h1000, 32'h100, 1'b0});
    tbl.push_back(vec_t'{1'b0, 32'h10, 32'h20, 32'hFFFF_FFF8, 1'b1, 32'h0, 32'h0, 32'h0, 1'b0, 32'h18, 32'h0, 1'b0});
    tbl.push_back(vec_t'{1'b1, 32'h0, 32'h100, 32'h7000, 1'b0, 32'h0, 32'h100, 32'h4000, 1'b1, 32'hFF, 32'h40FF, 1'b0});

    for (int k = 0; k < tbl.size(); k++) begin
      @(negedge clk);
      r_en = '0;
      set_rule(0, tbl[k].s0, tbl[k].e0, tbl[k].b0, tbl[k].en0);
      set_rule(1, tbl[k].s1, tbl[k].e1, tbl[k].b1, tbl[k].en1);
      slv_req = '0;
      mst_resp = '0;
      mst_resp.aw_ready = 1'b1;
      mst_resp.ar_ready = 1'b1;
      ax = rand_ax(tbl[k].addr);
      if (tbl[k].is_aw) begin slv_req.aw = ax; slv_req.aw_valid = 1'b1; end
      else begin slv_req.ar = ax; slv_req.ar_valid = 1'b1; end
      #1;
      chk($sformatf("vec%0d_miss", k), 128'(tbl[k].is_aw ? aw_miss : ar_miss), 128'(tbl[k].exp_miss));
      chk($sformatf("vec%0d_other_miss", k), 128'(tbl[k].is_aw ? ar_miss : aw_miss), 128'(0));
      @(negedge clk);
      slv_req.aw_valid = 1'b0;
      slv_req.ar_valid = 1'b0;
      #1;
      eax = ax;
      eax.addr = tbl[k].exp_addr;
      chk($sformatf("vec%0d_valid", k), 128'(tbl[k].is_aw ? mst_req.aw_valid : mst_req.ar_valid), 128'(1));
      chk($sformatf("vec%0d_payload", k), 128'(tbl[k].is_aw ? mst_req.aw : mst_req.ar), 128'(eax));
      chk($sformatf("vec%0d_miss_off", k), 128'(tbl[k].is_aw ? aw_miss : ar_miss), 128'(0));
    end

    // Backpressure: one beat held stable, rule change ignored, then full rate
    @(negedge clk);
    r_en = '0;
    set_rule(0, 32'h1000, 32'h2000, 32'h8000_0000, 1'b1);
    mst_resp = '0;
    slv_req = '0;
    ax = rand_ax(32'h1010);
    slv_req.ar = ax;
    slv_req.ar_valid = 1'b1;
    #1;
    chk("bp_first_ready", 128'(slv_resp.ar_ready), 128'(1));
    chk("bp_first_latency", 128'(mst_req.ar_valid), 128'(0));
    eax = ax;
    eax.addr = 32'h8000_0010;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      slv_req.ar = rand_ax(32'h1020 + 32'(k));
      if (k == 2) r_base[0] = 32'h9000_0000;
      #1;
      chk($sformatf("bp_stall%0d_ready", k), 128'(slv_resp.ar_ready), 128'(0));
      chk($sformatf("bp_stall%0d_valid", k), 128'(mst_req.ar_valid), 128'(1));
      chk($sformatf("bp_stall%0d_payload", k), 128'(mst_req.ar), 128'(eax));
    end
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      r_base[0] = 32'h8000_0000;
      mst_resp.ar_ready = 1'b1;
      slv_req.ar.addr = 32'h1100 + 32'(4 * j);
      #1;
      exp_a = (j == 0) ? 32'h8000_0010 : 32'h8000_0100 + 32'(4 * (j - 1));
      chk($sformatf("bb%0d_ready", j), 128'(slv_resp.ar_ready), 128'(1));
      chk($sformatf("bb%0d_valid", j), 128'(mst_req.ar_valid), 128'(1));
      chk($sformatf("bb%0d_addr", j), 128'(mst_req.ar.addr), 128'(exp_a));
    end
    @(negedge clk);
    slv_req.ar_valid = 1'b0;
    #1;
    chk("bb_last_addr", 128'(mst_req.ar.addr), 128'(32'h8000_0114));
    chk("bb_last_valid", 128'(mst_req.ar_valid), 128'(1));
    @(negedge clk); #1;
    chk("bb_empty", 128'(mst_req.ar_valid), 128'(0));

    // Narrow master address: offset and sum wrap mod 2^24
    @(negedge clk);
    s24_start[0] = 32'h0;
    s24_end[0]   = 32'hFFFF_FFFF;
    s24_base[0]  = 24'hFF_0000;
    s24_en[0]    = 1'b1;
    m24_resp.aw_ready = 1'b1;
    m24_resp.ar_ready = 1'b1;
    ax = rand_ax(32'h0002_0000);
    s24_req.ar = ax;
    s24_req.ar_valid = 1'b1;
    eax = rand_ax(32'hFFFF_FFFF);
    s24_req.aw = eax;
    s24_req.aw_valid = 1'b1;
    #1;
    chk("n24_ar_ready", 128'(s24_resp.ar_ready), 128'(1));
    chk("n24_ar_miss", 128'(ar_miss24), 128'(0));
    chk("n24_aw_miss", 128'(aw_miss24), 128'(1));
    @(negedge clk);
    s24_req.ar_valid = 1'b0;
    s24_req.aw_valid = 1'b0;
    #1;
    e24 = '{id: ax.id, addr: 24'h01_0000, len: ax.len, size: ax.size, burst: ax.burst,
            lock: ax.lock, cache: ax.cache, prot: ax.prot, qos: ax.qos};
    chk("n24_ar_valid", 128'(m24_req.ar_valid), 128'(1));
    chk("n24_ar", 128'(m24_req.ar), 128'(e24));
    e24 = '{id: eax.id, addr: 24'hFF_FFFF, len: eax.len, size: eax.size, burst: eax.burst,
            lock: eax.lock, cache: eax.cache, prot: eax.prot, qos: eax.qos};
    chk("n24_aw", 128'(m24_req.aw), 128'(e24));
    chk("n24_pass", 128'({m24_req.w, m24_req.w_valid, m24_req.b_ready, m24_req.r_ready}),
        128'({s24_req.w, s24_req.w_valid, s24_req.b_ready, s24_req.r_ready}));

    // Asynchronous reset while an AW beat is held
    @(negedge clk);
    r_en = '0;
    mst_resp = '0;
    slv_req = '0;
    ax = rand_ax(32'h4444);
    slv_req.aw = ax;
    slv_req.aw_valid = 1'b1;
    #1;
    chk("ar_hold_accept", 128'(slv_resp.aw_ready), 128'(1));
    @(negedge clk);
    slv_req.aw_valid = 1'b0;
    #1;
    chk("ar_hold_valid", 128'(mst_req.aw_valid), 128'(1));
    chk("ar_hold_payload", 128'(mst_req.aw), 128'(ax));
    #1;
    rst = 1'b1;
    #1;
    chk("async_rst_aw_valid", 128'(mst_req.aw_valid), 128'(0));
    chk("async_rst_aw_payload", 128'(mst_req.aw), 128'(0));
    chk("async_rst_aw_ready", 128'(slv_resp.aw_ready), 128'(1));
    rand_side();
    #1;
    chk_pass("in_rst");
    @(negedge clk);
    rst = 1'b0;
    mst_resp.aw_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      rand_side();
      #1;
      chk($sformatf("post_rst%0d_no_stale", k), 128'(mst_req.aw_valid), 128'(0));
      chk_pass("post_rst");
    end

    // Randomized run against the scoreboard
    @(negedge clk);
    rst = 1'b1;
    slv_req = '0;
    mst_resp = '0;
    q_aw.delete();
    q_ar.delete();
    @(negedge clk);
    rst = 1'b0;
    for (int n = 0; n < 800; n++) begin
      @(negedge clk);
      if (n % 40 == 0 || $urandom_range(0, 24) == 0) begin
        for (int i = 0; i < int'(NR); i++)
          set_rule(i, 32'($urandom_range(0, 32'h300)), 32'($urandom_range(0, 32'h400)),
                   32'($urandom), 1'($urandom));
      end
      slv_req.aw       = rand_ax(pick_addr());
      slv_req.aw_valid = 1'($urandom);
      slv_req.ar       = rand_ax(pick_addr());
      slv_req.ar_valid = 1'($urandom);
      rand_side();
      mst_resp.aw_ready = ($urandom_range(0, 3) != 0);
      mst_resp.ar_ready = ($urandom_range(0, 3) != 0);
      #1;
      chk_pass("rand");
      sb_step(1'b1);
      sb_step(1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
